// File: rtl/csr_access_ctrl_pkg.sv
// Shared definitions for the Zicsr access controller: widths, op encodings,
// FSM state encoding and small op-decoding helpers.
package csr_access_ctrl_pkg;

    localparam int CORE_REG_WIDTH = 64;
    localparam int CSR_ADDR_WIDTH = 12;
    localparam int CSR_ADDR_MSB   = CSR_ADDR_WIDTH - 1;

    // funct3 encodings of the Zicsr instructions
    typedef enum logic [2:0] {
        CSR_OP_RW  = 3'b001,
        CSR_OP_RS  = 3'b010,
        CSR_OP_RC  = 3'b011,
        CSR_OP_RWI = 3'b101,
        CSR_OP_RSI = 3'b110,
        CSR_OP_RCI = 3'b111
    } csr_op_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // addr[11:10] value marking a read-only CSR
    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    function automatic logic csr_op_is_imm(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic csr_op_is_swap(input logic [2:0] op);
        return (op == CSR_OP_RW) || (op == CSR_OP_RWI);
    endfunction

endpackage

// File: rtl/csr_access_ctrl_alu.sv
// Read-modify-write datapath: computes the new CSR value from the old value
// and the source operand according to the Zicsr op.
module csr_op_alu
    import csr_access_ctrl_pkg::*;
#(
    parameter int REG_WIDTH = CORE_REG_WIDTH
) (
    input  logic [2:0]           op,
    input  logic [REG_WIDTH-1:0] old_val,
    input  logic [REG_WIDTH-1:0] src_val,
    output logic [REG_WIDTH-1:0] new_val
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves new_val unassigned (no latch).
        new_val = old_val;
        case (op)
            CSR_OP_RW, CSR_OP_RWI: new_val = src_val;
            CSR_OP_RS, CSR_OP_RSI: new_val = old_val | src_val;
            CSR_OP_RC, CSR_OP_RCI: new_val = old_val & ~src_val;
            default:               new_val = old_val;
        endcase
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences one Zicsr instruction at a time onto the CSR regfile ports as an
// atomic read-modify-write, stalling the pipeline and yielding to traps.
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int REG_WIDTH = CORE_REG_WIDTH
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_n_i,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_op_i,
    input  logic [CSR_ADDR_MSB:0] req_addr_i,
    input  logic [REG_WIDTH-1:0]  req_rs1_data_i,
    input  logic [4:0]            req_zimm_i,
    input  logic                  req_rs1_zero_i,

    output logic                  rsp_valid_o,
    output logic [REG_WIDTH-1:0]  rsp_data_o,
    output logic                  rsp_illegal_o,
    output logic                  rsp_aborted_o,

    output logic                  pause_o,

    output logic                  csr_read_ena_o,
    output logic [CSR_ADDR_MSB:0] csr_read_addr_o,
    input  logic [REG_WIDTH-1:0]  csr_read_data_i,
    output logic                  csr_write_ena_o,
    output logic [CSR_ADDR_MSB:0] csr_write_addr_o,
    output logic [REG_WIDTH-1:0]  csr_write_data_o,
    input  logic                  trap_enter_i,
    input  logic                  trap_exit_i
);

    logic [1:0]            state_q;
    logic [2:0]            op_q;
    logic [CSR_ADDR_MSB:0] addr_q;
    logic [REG_WIDTH-1:0]  src_q;
    logic [REG_WIDTH-1:0]  old_q;
    logic [REG_WIDTH-1:0]  new_q;
    logic                  wr_intent_q;
    logic                  illegal_q;
    logic                  aborted_q;

    logic                  trap_any;
    logic                  accept;
    logic [REG_WIDTH-1:0]  alu_new;
    logic [REG_WIDTH-1:0]  req_src;

    assign trap_any = trap_enter_i | trap_exit_i;
    assign accept   = req_valid_i & req_ready_o;
    assign req_src  = csr_op_is_imm(req_op_i) ? REG_WIDTH'(req_zimm_i) : req_rs1_data_i;

    csr_op_alu #(
        .REG_WIDTH (REG_WIDTH)
    ) u_alu (
        .op      (op_q),
        .old_val (csr_read_data_i),
        .src_val (src_q),
        .new_val (alu_new)
    );

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            src_q       <= '0;
            old_q       <= '0;
            new_q       <= '0;
            wr_intent_q <= 1'b0;
            illegal_q   <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q        <= req_op_i;
                        addr_q      <= req_addr_i;
                        src_q       <= req_src;
                        wr_intent_q <= csr_op_is_swap(req_op_i) | ~req_rs1_zero_i;
                        illegal_q   <= 1'b0;
                        aborted_q   <= 1'b0;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_q     <= csr_read_data_i;
                    new_q     <= alu_new;
                    illegal_q <= wr_intent_q & (addr_q[CSR_ADDR_MSB -: 2] == CSR_RO_FIELD);
                    aborted_q <= trap_any;
                    state_q   <= ST_WRITE;
                end
                ST_WRITE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == ST_IDLE) & ~trap_any;
    assign pause_o     = (state_q != ST_IDLE) | (req_valid_i & ~req_ready_o);

    assign csr_read_ena_o  = (state_q == ST_READ);
    assign csr_read_addr_o = addr_q;

    // A trap in the write cycle itself cancels the write without waiting for a register.
    assign csr_write_ena_o  = (state_q == ST_WRITE) & wr_intent_q & ~illegal_q & ~aborted_q & ~trap_any;
    assign csr_write_addr_o = addr_q;
    assign csr_write_data_o = new_q;

    assign rsp_valid_o   = (state_q == ST_WRITE);
    assign rsp_data_o    = rsp_valid_o ? old_q : '0;
    assign rsp_illegal_o = rsp_valid_o & illegal_q;
    assign rsp_aborted_o = rsp_valid_o & (aborted_q | trap_any);

endmodule
